// File: rtl/vga_scanout.sv
// Read/display end of the 160x120 3-bit framebuffer: 640x480@60 VGA timing from CLOCK_50,
// with 4x pixel replication, one-cycle framebuffer read latency and registered video outputs.
`timescale 1ns / 1ps
module vga_scanout #(
  parameter int unsigned H_VIS = 640,
  parameter int unsigned V_VIS = 480
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  output logic [14:0] fb_rd_addr,
  input  logic [2:0]  fb_rd_data,
  output logic        frame_start,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam logic [9:0] HVis       = 10'(H_VIS);
  localparam logic [9:0] VVis       = 10'(V_VIS);
  localparam logic [9:0] HTotal     = 10'd800;
  localparam logic [9:0] VTotal     = 10'd525;
  localparam logic [9:0] HSyncStart = HVis + 10'd16;
  localparam logic [9:0] HSyncEnd   = HVis + 10'd16 + 10'd95;
  localparam logic [9:0] VSyncStart = VVis + 10'd10;
  localparam logic [9:0] VSyncEnd   = VVis + 10'd11;

  logic       pix_en_q, pix_en_d;
  logic       vga_clk_q, vga_clk_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_n_q, blank_n_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       frame_start_q, frame_start_d;
  logic       visible;

  always_comb begin
    visible    = (h_cnt_q < HVis) && (v_cnt_q < VVis);
    fb_rd_addr = '0;
    if (visible) begin
      fb_rd_addr = {8'd0, v_cnt_q[8:2]} * 15'd160 + {7'd0, h_cnt_q[9:2]};
    end
  end

  always_comb begin
    pix_en_d      = ~pix_en_q;
    // Lag ~pix_en by one cycle so VGA_CLK rises halfway through each pixel period.
    vga_clk_d     = ~pix_en_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    frame_start_d = pix_en_q && (h_cnt_q == HTotal - 10'd1) && (v_cnt_q == VTotal - 10'd1);

    if (pix_en_q) begin
      if (h_cnt_q == HTotal - 10'd1) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VTotal - 10'd1) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
      // fb_rd_data now holds the word addressed by the current counters.
      hs_d      = !((h_cnt_q >= HSyncStart) && (h_cnt_q <= HSyncEnd));
      vs_d      = !((v_cnt_q >= VSyncStart) && (v_cnt_q <= VSyncEnd));
      blank_n_d = visible;
      r_d       = (visible && fb_rd_data[2]) ? 8'hFF : 8'h00;
      g_d       = (visible && fb_rd_data[1]) ? 8'hFF : 8'h00;
      b_d       = (visible && fb_rd_data[0]) ? 8'hFF : 8'h00;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= pix_en_d;
      vga_clk_q     <= vga_clk_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: random framebuffer contents, scan position modelled as a linear pixel
// index derived from elapsed clock edges; counters are jumped forward to reach late-frame lines.
`timescale 1ns / 1ps
module tb_vga_scanout;

  localparam int HVis      = 640;
  localparam int VVis      = 480;
  localparam int FramePix  = 800 * 525;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [14:0] fb_rd_addr;
  logic [2:0]  fb_rd_data;
  logic        frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0]  vga_r, vga_g, vga_b;

  logic [2:0]  fb_mem [19200];

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release, pixel index held by the counters, and the
  // index the registered outputs currently describe.
  int t;
  int cur;
  int out_idx;
  bit out_valid;
  bit fs_exp;

  always #10 clk = ~clk;

  vga_scanout #(.H_VIS(HVis), .V_VIS(VVis)) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .fb_rd_addr (fb_rd_addr),
    .fb_rd_data (fb_rd_data),
    .frame_start(frame_start),
    .VGA_CLK    (vga_clk),
    .VGA_HS     (vga_hs),
    .VGA_VS     (vga_vs),
    .VGA_BLANK_N(vga_blank_n),
    .VGA_SYNC_N (vga_sync_n),
    .VGA_R      (vga_r),
    .VGA_G      (vga_g),
    .VGA_B      (vga_b)
  );

  always @(posedge clk) begin
    fb_rd_data <= (fb_rd_addr < 15'd19200) ? fb_mem[fb_rd_addr] : 3'b000;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %h expected %h", tag, t, obs, exp);
    end
  endtask

  function automatic logic [14:0] exp_addr(input int idx);
    int h, v;
    h = idx % 800;
    v = idx / 800;
    if (h < HVis && v < VVis) return 15'((v / 4) * 160 + h / 4);
    return 15'd0;
  endfunction

  // {hs, vs, blank_n, r, g, b}
  function automatic logic [26:0] exp_video(input int idx);
    int h, v;
    logic [2:0] d;
    logic vis;
    h   = idx % 800;
    v   = idx / 800;
    vis = (h < HVis) && (v < VVis);
    d   = fb_mem[exp_addr(idx)];
    return {!(h >= 656 && h <= 751), !(v >= 490 && v <= 491), vis,
            (vis && d[2]) ? 8'hFF : 8'h00, (vis && d[1]) ? 8'hFF : 8'h00,
            (vis && d[0]) ? 8'hFF : 8'h00};
  endfunction

  task automatic check_all();
    logic [26:0] reset_video;
    reset_video = {1'b1, 1'b1, 1'b0, 24'h0};
    check_eq("addr", fb_rd_addr, exp_addr(cur));
    check_eq("video", {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b},
             out_valid ? exp_video(out_idx) : reset_video);
    check_eq("frame_start", frame_start, fs_exp);
    check_eq("vga_clk_sync_n", {vga_clk, vga_sync_n}, {(t == 0) || (t % 2 == 1), 1'b0});
  endtask

  // Advance one CLOCK_50 edge: the counters move on every second edge after release.
  task automatic step();
    @(posedge clk);
    t++;
    fs_exp = 1'b0;
    if (t >= 2 && t % 2 == 0) begin
      out_valid = 1'b1;
      out_idx   = cur;
      cur       = (cur + 1) % FramePix;
      fs_exp    = (cur == 0);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic model_reset();
    t         = 0;
    cur       = 0;
    out_idx   = 0;
    out_valid = 1'b0;
    fs_exp    = 1'b0;
  endtask

  // Called at a negedge following an even edge, while the counters are stable for two edges.
  task automatic jump_to(input int idx);
    cur = idx;
    force dut.h_cnt_q = 10'(idx % 800);
    force dut.v_cnt_q = 10'(idx / 800);
    step();
    release dut.h_cnt_q;
    release dut.v_cnt_q;
  endtask

  task automatic reset_pulse(input int hold);
    resetn = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (hold) begin
      @(negedge clk);
      check_all();
    end
    resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) fb_mem[i] = 3'($urandom_range(0, 7));
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    resetn = 1'b1;

    // First lines of a frame: replication, line wrap, HS window.
    repeat (4000) step();

    // Mid-frame reset at (300, 200) aborts the scan immediately.
    jump_to(200 * 800 + 290);
    repeat (19) step();
    reset_pulse($urandom_range(2, 6));
    repeat (2400) step();

    // Bottom of the frame: VS window, frame wrap and the frame_start pulse.
    jump_to(489 * 800 + 600);
    repeat (58400) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
